// File: rtl/jt12_mixacc.sv
// ---------------------------------------------------------------------------
// jt12_mixacc
// Stereo operator/PCM frame accumulator. Enabled operator slots (or one PCM
// sample per frame) are summed over a frame of SLOTS clk_en slots. At each
// frame start the running sums move to hold registers. On the following
// clk_en edge the held values are scaled by the selected gain and limited
// (saturate or wrap), then presented on left/right with a one-clock
// sample_rdy pulse.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   clk_en       slot advance enable (all state holds when low)
//   zero         force a frame start on this slot
//   op_result    signed operator output for the current slot (WIN)
//   sum_en       current slot is a carrier to be summed
//   pcm_slot     current slot belongs to the PCM-capable channel
//   pcm_en       PCM replaces operator data on pcm_slot slots
//   pcm          signed PCM sample (WIN)
//   rl           {left enable, right enable}, sampled per slot
//   gain         0:x1 1:x1.25 2:x1.5 3:x2
//   clr_ovf      clear sticky overflow flags (acts without clk_en)
//   left, right  signed output samples (WOUT)
//   sample_rdy   one-clock strobe: left/right just updated
//   ovf_l, ovf_r sticky overflow flags
// ---------------------------------------------------------------------------
module jt12_mixacc #(
  parameter int WIN   = 9,
  parameter int WOUT  = 12,
  parameter int SLOTS = 24,
  parameter int LIMIT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   zero,
  input  logic signed [WIN-1:0]  op_result,
  input  logic                   sum_en,
  input  logic                   pcm_slot,
  input  logic                   pcm_en,
  input  logic signed [WIN-1:0]  pcm,
  input  logic [1:0]             rl,
  input  logic [1:0]             gain,
  input  logic                   clr_ovf,
  output logic signed [WOUT-1:0] left,
  output logic signed [WOUT-1:0] right,
  output logic                   sample_rdy,
  output logic                   ovf_l,
  output logic                   ovf_r
);

  localparam int CW = (SLOTS > 2) ? $clog2(SLOTS) : 1;
  localparam int XW = WOUT + 2;  // wide enough for acc+in and for hold*2

  localparam logic signed [XW-1:0] MAXV = {3'b000, {(WOUT-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {3'b111, {(WOUT-1){1'b0}}};

  // Reduce a wide value to WOUT bits: clamp when LIMIT, otherwise keep low bits.
  function automatic logic signed [WOUT-1:0] lim(input logic signed [XW-1:0] v);
    if (LIMIT != 0) begin
      if (v > MAXV) return MAXV[WOUT-1:0];
      if (v < MINV) return MINV[WOUT-1:0];
    end
    return v[WOUT-1:0];
  endfunction

  function automatic logic out_of_range(input logic signed [XW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  // Gain by shift-and-add; arithmetic shifts floor toward minus infinity.
  function automatic logic signed [XW-1:0] apply_gain(input logic signed [WOUT-1:0] h,
                                                      input logic [1:0] g);
    logic signed [XW-1:0] hx;
    hx = {{2{h[WOUT-1]}}, h};
    case (g)
      2'd0:    return hx;
      2'd1:    return hx + (hx >>> 2);
      2'd2:    return hx + (hx >>> 1);
      default: return hx <<< 1;
    endcase
  endfunction

  logic [CW-1:0]         slot_cnt;
  logic                  pcm_pend;
  logic                  gain_go;
  logic signed [WOUT-1:0] acc_l, acc_r;
  logic signed [WOUT-1:0] hold_l, hold_r;

  logic                  frame_start;
  logic                  use_pcm;
  logic                  pend_eff;
  logic                  en_l, en_r;
  logic signed [XW-1:0]  in_ext;
  logic signed [XW-1:0]  sum_l, sum_r;
  logic signed [XW-1:0]  g_l, g_r;
  logic signed [WOUT-1:0] acc_nxt_l, acc_nxt_r;
  logic                  acc_ovf_l, acc_ovf_r;
  logic                  set_l, set_r;
  logic [CW-1:0]         slot_nxt;

  // Slot input selection and accumulate path
  always_comb begin
    frame_start = zero | (slot_cnt == '0);
    use_pcm     = pcm_slot & pcm_en;
    pend_eff    = frame_start | pcm_pend;
    // PCM is summed only on the first PCM slot of a frame; later PCM slots add zero.
    if (use_pcm)
      in_ext = pend_eff ? {{(XW-WIN){pcm[WIN-1]}}, pcm} : '0;
    else
      in_ext = {{(XW-WIN){op_result[WIN-1]}}, op_result};
    en_l  = (sum_en | use_pcm) & rl[1];
    en_r  = (sum_en | use_pcm) & rl[0];
    sum_l = {{2{acc_l[WOUT-1]}}, acc_l} + in_ext;
    sum_r = {{2{acc_r[WOUT-1]}}, acc_r} + in_ext;

    if (frame_start) begin
      acc_nxt_l = en_l ? lim(in_ext) : '0;
      acc_nxt_r = en_r ? lim(in_ext) : '0;
      acc_ovf_l = en_l & out_of_range(in_ext);
      acc_ovf_r = en_r & out_of_range(in_ext);
    end else begin
      acc_nxt_l = en_l ? lim(sum_l) : acc_l;
      acc_nxt_r = en_r ? lim(sum_r) : acc_r;
      acc_ovf_l = en_l & out_of_range(sum_l);
      acc_ovf_r = en_r & out_of_range(sum_r);
    end

    if (frame_start)
      slot_nxt = CW'(1);
    else if (slot_cnt == CW'(SLOTS-1))
      slot_nxt = '0;
    else
      slot_nxt = slot_cnt + CW'(1);

    g_l   = apply_gain(hold_l, gain);
    g_r   = apply_gain(hold_r, gain);
    set_l = clk_en & (acc_ovf_l | (gain_go & out_of_range(g_l)));
    set_r = clk_en & (acc_ovf_r | (gain_go & out_of_range(g_r)));
  end

  // Slot counter, PCM pending flag and accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      pcm_pend <= 1'b1;
      gain_go  <= 1'b0;
      acc_l    <= '0;
      acc_r    <= '0;
      hold_l   <= '0;
      hold_r   <= '0;
    end else if (clk_en) begin
      slot_cnt <= slot_nxt;
      if (use_pcm)
        pcm_pend <= 1'b0;
      else if (frame_start)
        pcm_pend <= 1'b1;
      gain_go <= frame_start;
      if (frame_start) begin
        hold_l <= acc_l;
        hold_r <= acc_r;
      end
      acc_l <= acc_nxt_l;
      acc_r <= acc_nxt_r;
    end
  end

  // Gain/output stage: one clk_en after the frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left       <= '0;
      right      <= '0;
      sample_rdy <= 1'b0;
    end else begin
      sample_rdy <= 1'b0;
      if (clk_en && gain_go) begin
        left       <= lim(g_l);
        right      <= lim(g_r);
        sample_rdy <= 1'b1;
      end
    end
  end

  // Sticky overflow: a new overflow wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_l <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      ovf_l <= (ovf_l & ~clr_ovf) | set_l;
      ovf_r <= (ovf_r & ~clr_ovf) | set_r;
    end
  end

endmodule

// File: tb/tb_jt12_mixacc.sv
// ---------------------------------------------------------------------------
// tb_jt12_mixacc
// Directed bench for jt12_mixacc. Two instances share all inputs: u_sat
// (LIMIT=1) and u_wrap (LIMIT=0). Each frame is driven as a burst of clk_en
// slots; the result of a frame appears on slot 1 of the following frame, so
// each frame's output is checked after the next frame has been driven.
// ---------------------------------------------------------------------------
module tb_jt12_mixacc;

  logic              clk;
  logic              rst_n;
  logic              clk_en;
  logic              zero;
  logic signed [8:0] op_result;
  logic              sum_en;
  logic              pcm_slot;
  logic              pcm_en;
  logic signed [8:0] pcm;
  logic [1:0]        rl;
  logic [1:0]        gain;
  logic              clr_ovf;

  logic signed [11:0] left, right, w_left, w_right;
  logic               sample_rdy, ovf_l, ovf_r;
  logic               w_sample_rdy, w_ovf_l, w_ovf_r;

  int n_chk = 0;
  int n_err = 0;
  int rdy_total = 0;
  int f_rdy_n;
  int f_rdy_slot;
  int rdy_snap;

  jt12_mixacc #(.WIN(9), .WOUT(12), .SLOTS(24), .LIMIT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .zero(zero),
    .op_result(op_result), .sum_en(sum_en), .pcm_slot(pcm_slot),
    .pcm_en(pcm_en), .pcm(pcm), .rl(rl), .gain(gain), .clr_ovf(clr_ovf),
    .left(left), .right(right), .sample_rdy(sample_rdy),
    .ovf_l(ovf_l), .ovf_r(ovf_r)
  );

  jt12_mixacc #(.WIN(9), .WOUT(12), .SLOTS(24), .LIMIT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .zero(zero),
    .op_result(op_result), .sum_en(sum_en), .pcm_slot(pcm_slot),
    .pcm_en(pcm_en), .pcm(pcm), .rl(rl), .gain(gain), .clr_ovf(clr_ovf),
    .left(w_left), .right(w_right), .sample_rdy(w_sample_rdy),
    .ovf_l(w_ovf_l), .ovf_r(w_ovf_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (sample_rdy) rdy_total++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive nslots consecutive clk_en slots. sum_en on slots < nen, pcm_slot
  // on slots < npcm, zero on slot 0 when z is set.
  task automatic frame(input int op, input int nen, input int npcm,
                       input logic [1:0] rlv, input int nslots, input bit z);
    f_rdy_n    = 0;
    f_rdy_slot = -1;
    for (int s = 0; s < nslots; s++) begin
      zero      = z && (s == 0);
      op_result = 9'(op);
      sum_en    = (s < nen);
      pcm_slot  = (s < npcm);
      rl        = rlv;
      clk_en    = 1'b1;
      @(posedge clk);
      #1;
      if (sample_rdy) begin
        f_rdy_n++;
        f_rdy_slot = s;
      end
    end
    clk_en   = 1'b0;
    zero     = 1'b0;
    sum_en   = 1'b0;
    pcm_slot = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; zero = 1'b0; op_result = '0; sum_en = 1'b0;
    pcm_slot = 1'b0; pcm_en = 1'b0; pcm = '0; rl = 2'b11; gain = 2'd0;
    clr_ovf = 1'b0;
    #2;
    chk("reset_left", left, 0);
    chk("reset_right", right, 0);
    chk("reset_rdy", sample_rdy, 0);
    chk("reset_ovf_l", ovf_l, 0);
    chk("reset_ovf_r", ovf_r, 0);
    #10;
    rst_n = 1'b1;

    // Basic sum: 24 x 10 = 240, sample_rdy once per frame on slot 1
    frame(10, 24, 0, 2'b11, 24, 1'b1);
    chk("f1_rdy_slot", f_rdy_slot, 1);
    frame(10, 24, 0, 2'b11, 24, 1'b1);
    chk("sum240_left", left, 240);
    chk("sum240_right", right, 240);
    chk("f2_rdy_n", f_rdy_n, 1);
    chk("f2_rdy_slot", f_rdy_slot, 1);

    // Saturation vs wrap: 24 x 100 = 2400
    frame(100, 24, 0, 2'b11, 24, 1'b1);
    frame(255, 24, 0, 2'b11, 24, 1'b1);
    chk("sat2400_left", left, 2047);
    chk("sat_ovf_l", ovf_l, 1);
    chk("wrap2400_left", w_left, -1696);
    chk("wrap_ovf_l", w_ovf_l, 1);
    frame(-256, 24, 0, 2'b11, 24, 1'b1);
    chk("sat255_left", left, 2047);
    frame(0, 0, 0, 2'b11, 24, 1'b1);
    chk("satneg_left", left, -2048);
    chk("satneg_right", right, -2048);

    // Gain: 8 x 100 = 800, 15 x 100 = 1500
    pulse_clr();
    chk("clr_ovf_l", ovf_l, 0);
    chk("clr_ovf_r", ovf_r, 0);
    frame(100, 8, 0, 2'b11, 24, 1'b1);
    gain = 2'd1;
    frame(100, 8, 0, 2'b11, 24, 1'b1);
    chk("gain125_left", left, 1000);
    gain = 2'd2;
    frame(100, 15, 0, 2'b11, 24, 1'b1);
    chk("gain15_left", left, 1200);
    chk("gain15_ovf_l", ovf_l, 0);
    gain = 2'd3;
    frame(0, 0, 0, 2'b11, 24, 1'b1);
    chk("gain2_left", left, 2047);
    chk("gain2_ovf_l", ovf_l, 1);
    chk("gain2_wrap_left", w_left, -1096);
    pulse_clr();
    chk("clr2_ovf_l", ovf_l, 0);
    gain = 2'd0;

    // PCM summed once per frame
    pcm_en = 1'b1;
    pcm    = 9'sd100;
    frame(7, 0, 4, 2'b11, 24, 1'b1);
    pcm_en = 1'b0;
    frame(7, 4, 4, 2'b11, 24, 1'b1);
    chk("pcm_once_left", left, 100);
    chk("pcm_once_right", right, 100);
    frame(0, 0, 0, 2'b11, 24, 1'b1);
    chk("pcm_off_left", left, 28);

    // Left only
    frame(5, 24, 0, 2'b10, 24, 1'b1);
    frame(5, 24, 0, 2'b10, 24, 1'b1);
    chk("rl10_left", left, 120);
    chk("rl10_right", right, 0);

    // zero after 10 slots: partial sum emitted, new frame counts from there
    frame(5, 24, 0, 2'b11, 10, 1'b1);
    frame(5, 24, 0, 2'b11, 24, 1'b1);
    chk("zero_partial_left", left, 50);
    chk("zero_partial_right", right, 50);
    chk("zero_rdy_slot", f_rdy_slot, 1);
    frame(0, 0, 0, 2'b11, 24, 1'b0);
    chk("zero_next_rdy_n", f_rdy_n, 1);
    chk("zero_next_rdy_slot", f_rdy_slot, 1);
    chk("zero_next_left", left, 120);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_left", left, 0);
    chk("arst_right", right, 0);
    chk("arst_wrap_left", w_left, 0);
    chk("arst_rdy", sample_rdy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_snap = rdy_total;
    repeat (50) @(posedge clk);
    #1;
    chk("idle_rdy_count", rdy_total, rdy_snap);
    chk("idle_left", left, 0);
    frame(3, 24, 0, 2'b11, 24, 1'b0);
    chk("post_rst_rdy_slot", f_rdy_slot, 1);
    frame(0, 0, 0, 2'b11, 24, 1'b0);
    chk("post_rst_left", left, 72);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
